// File: rtl/mask_encoder.sv
// Sequential bitmask encoder: walks a WORD-bit mask and emits the index of each
// set bit, lowest first, one per idx handshake.
module mask_encoder #(
  parameter int WORD = 32,
  parameter int IDX  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [WORD-1:0] load_mask,
  output logic            idx_valid,
  input  logic            idx_ready,
  output logic [IDX-1:0]  idx,
  output logic            idx_last,
  output logic [IDX:0]    remaining,
  output logic            done,
  output logic            state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends on ready, and offered data holds until taken.

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  localparam logic [IDX:0]    ONE = (IDX+1)'(1);
  localparam logic [IDX:0]    TWO = (IDX+1)'(2);
  localparam logic [WORD-1:0] BIT0 = {{(WORD-1){1'b0}}, 1'b1};

  state_t          state;
  logic [WORD-1:0] pending;
  logic [WORD-1:0] cleared;
  logic [IDX-1:0]  next_low;
  logic [IDX-1:0]  load_low;
  logic [IDX:0]    load_cnt;

  function automatic logic [IDX-1:0] lowest(input logic [WORD-1:0] v);
    lowest = '0;
    for (int i = WORD - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDX'(i);
    end
  endfunction

  function automatic logic [IDX:0] popcnt(input logic [WORD-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WORD; i++) begin
      popcnt = popcnt + (IDX+1)'(v[i]);
    end
  endfunction

  always_comb begin
    cleared  = pending & ~(BIT0 << idx);
    next_low = lowest(cleared);
    load_low = lowest(load_mask);
    load_cnt = popcnt(load_mask);
  end

  assign load_ready = (state == IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      idx_valid <= 1'b0;
      idx       <= '0;
      idx_last  <= 1'b0;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid) begin
            if (load_mask != '0) begin
              pending   <= load_mask;
              idx       <= load_low;
              remaining <= load_cnt;
              idx_last  <= (load_cnt == ONE);
              idx_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              // An empty mask is consumed immediately.
              done <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (idx_valid && idx_ready) begin
            pending   <= cleared;
            remaining <= remaining - ONE;
            if (cleared != '0) begin
              idx      <= next_low;
              idx_last <= (remaining == TWO);
            end else begin
              idx_valid <= 1'b0;
              idx_last  <= 1'b0;
              done      <= 1'b1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_encoder.sv
// Bench for mask_encoder: directed scenarios plus random traffic, checked each
// cycle against a queue of expected indices built from the loaded mask.
module tb_mask_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_mask;
  logic        idx_valid;
  logic        idx_ready;
  logic [4:0]  idx;
  logic        idx_last;
  logic [5:0]  remaining;
  logic        done;
  logic        state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q[$];
  logic        exp_done;

  always #5 clk = ~clk;

  mask_encoder #(.WORD(32), .IDX(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_mask  (load_mask),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx        (idx),
    .idx_last   (idx_last),
    .remaining  (remaining),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic check_outputs();
    logic busy;
    busy = (exp_q.size() != 0);
    check("load_ready", 32'(load_ready), 32'(!busy));
    check("state_dbg", 32'(state_dbg), 32'(busy));
    check("idx_valid", 32'(idx_valid), 32'(busy));
    check("done", 32'(done), 32'(exp_done));
    if (busy) begin
      check("idx", 32'(idx), exp_q[0]);
      check("remaining", 32'(remaining), 32'(exp_q.size()));
      check("idx_last", 32'(idx_last), 32'(exp_q.size() == 1));
    end else begin
      check("remaining_idle", 32'(remaining), 32'd0);
      check("idx_last_idle", 32'(idx_last), 32'd0);
    end
  endtask

  // Called on a falling edge: check, drive, advance the model over the next rising edge.
  task automatic step(input logic lv, input logic [31:0] m, input logic rdy);
    logic busy;
    check_outputs();
    load_valid = lv;
    load_mask  = m;
    idx_ready  = rdy;
    busy       = (exp_q.size() != 0);
    exp_done   = 1'b0;
    if (busy) begin
      if (rdy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end
    end else if (lv) begin
      for (int i = 0; i < 32; i++) begin
        if (m[i]) exp_q.push_back(32'(i));
      end
      if (exp_q.size() == 0) exp_done = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drain_random(input logic lv, input logic [31:0] m);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
      step(lv, m, 1'($urandom_range(0, 1)));
    end
    check("drain_bound", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] rm;
    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_mask  = '0;
    idx_ready  = 1'b0;
    exp_done   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_idx", 32'(idx), 32'd0);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Single bit
    step(1'b1, 32'h0000_0001, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);

    // Sparse mask at full throughput
    step(1'b1, 32'h8000_0011, 1'b1);
    repeat (4) step(1'b0, 32'h0, 1'b1);

    // Full mask with random stalls
    step(1'b1, 32'hFFFF_FFFF, 1'b0);
    drain_random(1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b0);

    // Zero mask
    step(1'b1, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, 1'b0);

    // Load held while busy; taken in the bubble after done
    step(1'b1, 32'h0000_0030, 1'b0);
    drain_random(1'b1, 32'h0000_0002);
    step(1'b1, 32'h0000_0002, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Asynchronous reset mid-burst
    step(1'b1, 32'h0000_00F0, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    #2 rst_n = 1'b0;
    load_valid = 1'b0;
    idx_ready  = 1'b0;
    #1;
    check("arst_idx_valid", 32'(idx_valid), 32'd0);
    check("arst_idx", 32'(idx), 32'd0);
    check("arst_idx_last", 32'(idx_last), 32'd0);
    check("arst_remaining", 32'(remaining), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_load_ready", 32'(load_ready), 32'd1);
    exp_q.delete();
    exp_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0000_0100, 1'b0);
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: rm = $urandom();
        1: rm = $urandom() & $urandom() & $urandom();
        2: rm = 32'h0;
        3: rm = 32'h1 << $urandom_range(0, 31);
        default: rm = $urandom() | 32'h8000_0001;
      endcase
      step(1'($urandom_range(0, 1)), rm, 1'($urandom_range(0, 3) != 0));
    end
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mask_encoder.md
# mask_encoder

Sequential 32-to-5 bitmask encoder, the inverse of the register-select decoder. It accepts a WORD-bit mask and emits the 5-bit index of every set bit, lowest index first, one index per handshake. Used to walk a register-select or write-enable mask back into register numbers, for example for register-file scrubbing, save/restore sequencing, and debug dump.

## Interface
- WORD, 32: mask width; must be a power of two ≥ 2.
- IDX, 5: index width; equals log2(WORD).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- load_valid  in  1  new mask offered.
- load_ready  out  1  block idle and able to take a mask.
- load_mask  in  WORD  mask to encode; bit i maps to index i.
- idx_valid  out  1  idx is valid.
- idx_ready  in  1  consumer accepts idx.
- idx  out  IDX  index of the lowest still-pending set bit.
- idx_last  out  1  current idx is the final one of this mask.
- remaining  out  IDX+1  set bits not yet accepted, including the current one (0..WORD).
- done  out  1  one-cycle pulse when a mask has been fully consumed.

## Operation
- Two states, IDLE and EMIT. Register `pending[WORD-1:0]` holds the unconsumed bits.
- load_ready = (state == IDLE). It is combinational from the state.
- IDLE, load_valid=1, load_mask≠0:
  - pending ← load_mask; idx ← lowest set bit of load_mask; remaining ← popcount(load_mask); idx_last ← (popcount==1).
  - idx_valid ← 1; go to EMIT.
- IDLE, load_valid=1, load_mask=0: mask is accepted, state stays IDLE, done ← 1 for one cycle, idx_valid stays 0.
- EMIT, idx_valid and idx_ready both high (accept):
  - pending ← pending with bit idx cleared; remaining ← remaining−1.
  - If the new pending ≠ 0: idx ← its lowest set bit; idx_last ← (remaining−1 == 1); stay in EMIT.
  - Else: idx_valid ← 0, idx_last ← 0, done ← 1 for one cycle, go to IDLE.
- EMIT without an accept: idx, idx_last, remaining, and pending hold stable.
- load_valid during EMIT is ignored because load_ready=0. The upstream must hold its mask.
- idx is a pure bit position: bit i set produces idx == i, the exact inverse of the decoder mapping.
- remaining is IDX+1 bits wide so that WORD (32) is representable. It never underflows, because it only decrements on an accept while ≥1.

## Timing
- Reset (rst_n=0, asynchronous):
  - Outputs: idx_valid=0, idx=0, idx_last=0, remaining=0, done=0, load_ready=1.
  - Internal: state=IDLE, pending=0.
- Reset mid-EMIT discards the remaining indices immediately, with no done pulse.
- Latency from load to first index: load accepted on edge N; idx_valid=1 with the first idx in cycle N+1.
- Throughput: one index per cycle while idx_ready is held at 1. A mask with k set bits drains in k cycles.
- done asserts in the cycle after the last accept, or after a zero-mask load, for exactly one cycle.
- Back-to-back masks: load_ready returns to 1 in the cycle after the last accept. The earliest next load is that cycle, so there is a one-cycle bubble between masks.
- All outputs except load_ready are registered. There is no combinational path from idx_ready or load_valid to any output.

## Test plan
- Single bit: load 0x0000_0001 → next cycle idx=0, idx_last=1, remaining=1. After accept: idx_valid=0, done pulses once, load_ready=1.
- Sparse mask: load 0x8000_0011 with idx_ready=1 → idx 0, 4, 31 on three consecutive cycles; remaining 3, 2, 1; idx_last only with 31; done on the 4th cycle.
- Full mask with stalls: load 0xFFFF_FFFF with idx_ready random at 50% → indices 0..31 in order, none skipped or repeated; remaining starts at 32; outputs stable during every stall cycle.
- Zero mask: load 0x0000_0000 → idx_valid never asserts, done pulses the following cycle, load_ready stays 1.
- Load ignored while busy: during EMIT, drive load_valid=1 with 0x0000_0002 → load_ready=0 and the current sequence is unaffected. After done, the held mask loads and emits idx=1.
- Reset mid-burst: load 0x0000_00F0, accept two indices, pull rst_n low asynchronously → all outputs take reset values immediately with no done pulse. After release, load 0x0000_0100 → idx=8, remaining=1.
